uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_if.sv | 18 +
 rtl/uart_baud_tick.sv | 16 +
 rtl/uart_rx.sv | 118 +++++++++++
 tb/tb_uart_rx.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, frame-config layout and baud divisor helper.
package uart_pkg;
    typedef enum logic [1:0] {BAUD_9600, BAUD_19200, BAUD_115200, BAUD_256000} baud_rate_e;
    localparam int StopCfgWidth  = 2;
    localparam int DataCfgWidth  = 2;
    localparam int TotalCfgWidth = 5;
    localparam int DataWidthMax  = 8;
    localparam int DataWidthMin  = 5;
    localparam int StopWidthMin  = 1;
    typedef struct packed {
        logic [DataCfgWidth-1:0] data_cfg;
        logic [StopCfgWidth-1:0] stop_cfg;
        logic                    parity_en;
    } uart_cfg_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} uart_rx_state_e;
    function automatic logic [15:0] get_baud_divisor(input int clk_hz, input logic [1:0] baud_sel);
        int baud;
        baud = (baud_sel == BAUD_9600) ? 9600 : (baud_sel == BAUD_19200) ? 19200 :
               (baud_sel == BAUD_115200) ? 115200 : 256000;
        return 16'(clk_hz / (baud * 16));
    endfunction
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial input, frame config and valid/ready word output of the receiver.
interface uart_rx_if;
    import uart_pkg::*;
    logic                     rx_i;
    logic [TotalCfgWidth-1:0] cfg_i;
    logic [1:0]               baud_sel_i;
    logic [DataWidthMax-1:0]  rx_data_o;
    logic                     rx_parity_err_o;
    logic                     rx_frame_err_o;
    logic                     rx_valid_o;
    logic                     rx_ready_i;
    logic                     overrun_o;
    logic                     busy_o;
    modport master (input rx_i, cfg_i, baud_sel_i, rx_ready_i,
                    output rx_data_o, rx_parity_err_o, rx_frame_err_o, rx_valid_o, overrun_o, busy_o);
    modport slave (output rx_i, cfg_i, baud_sel_i, rx_ready_i,
                   input rx_data_o, rx_parity_err_o, rx_frame_err_o, rx_valid_o, overrun_o, busy_o);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick generator, one tick every divisor clocks, restartable.
module uart_baud_tick #(
    parameter int Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             restart_i,
    input  logic [Width-1:0] divisor_i,
    output logic             tick_o
);
    logic [Width-1:0] cnt;
    assign tick_o = cnt == divisor_i - Width'(1);
    always_ff @(posedge clk_i)
        if (rst_i || restart_i || tick_o) cnt <= '0;
        else cnt <= cnt + Width'(1);
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampled UART receiver with one-entry valid/ready output buffer.
// Define UART_RX_MAJORITY_VOTE_EN to vote each bit over ticks 6/7/8 instead of sampling tick 7.
module uart_rx
    import uart_pkg::*;
#(
    parameter int ClkFreqHz  = 50_000_000,
    parameter int Oversample = 16
) (
    input logic      clk_i,
    input logic      rst_i,
    uart_rx_if.master bus
);
    if (Oversample != 16) begin : g_bad_oversample
        $error("uart_rx: Oversample must be 16");
    end
    logic s1, rxs, rxs_d, fall, start, tick, samp, bit_v, deliver, last_data, last_stop;
    logic [3:0] samp_cnt;
    logic [2:0] bit_cnt;
    logic [15:0] div_q;
    logic [DataWidthMax-1:0] shift;
    logic perr, ferr;
    uart_cfg_t cfg_q;
    uart_rx_state_e state, state_n;
    always_ff @(posedge clk_i)
        if (rst_i) {s1, rxs, rxs_d} <= 3'b111;
        else {s1, rxs, rxs_d} <= {bus.rx_i, s1, rxs};
    assign fall  = rxs_d & ~rxs;
    assign start = (state == RX_IDLE) && fall;
    uart_baud_tick u_tick (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .restart_i (start),
        .divisor_i (div_q),
        .tick_o    (tick)
    );
    always_ff @(posedge clk_i)
        if (rst_i || start) samp_cnt <= '0;
        else if (tick) samp_cnt <= samp_cnt + 4'd1;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [3:0] SampPt = 4'd8;
    logic v6, v7;
    always_ff @(posedge clk_i)
        if (rst_i) {v6, v7} <= 2'b11;
        else begin
            if (tick && samp_cnt == 4'd6) v6 <= rxs;
            if (tick && samp_cnt == 4'd7) v7 <= rxs;
        end
    assign bit_v = (v6 & v7) | (v6 & rxs) | (v7 & rxs);
`else
    localparam logic [3:0] SampPt = 4'd7;
    assign bit_v = rxs;
`endif
    assign samp      = tick && samp_cnt == SampPt;
    assign last_data = bit_cnt == {1'b0, cfg_q.data_cfg} + 3'(DataWidthMin - 1);
    // reserved stop_cfg 3 behaves as a single stop bit
    assign last_stop = bit_cnt[1:0] == ((cfg_q.stop_cfg == 2'd3) ? 2'd0 : cfg_q.stop_cfg);
    always_comb begin
        state_n = state;
        deliver = 1'b0;
        case (state)
            RX_IDLE:   state_n = fall ? RX_START : RX_IDLE;
            RX_START:  state_n = samp ? (bit_v ? RX_IDLE : RX_DATA) : RX_START;
            RX_DATA:   state_n = (samp && last_data) ? (cfg_q.parity_en ? RX_PARITY : RX_STOP) : RX_DATA;
            RX_PARITY: state_n = samp ? RX_STOP : RX_PARITY;
            RX_STOP: begin
                deliver = samp && last_stop;
                state_n = deliver ? RX_IDLE : RX_STOP;
            end
            default:   state_n = RX_IDLE;
        endcase
    end
    always_ff @(posedge clk_i)
        if (rst_i) begin
            state   <= RX_IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            cfg_q   <= '0;
            div_q   <= '0;
        end else begin
            state <= state_n;
            if (start) begin
                cfg_q   <= uart_cfg_t'(bus.cfg_i);
                div_q   <= get_baud_divisor(ClkFreqHz, bus.baud_sel_i);
                shift   <= '0;
                perr    <= 1'b0;
                ferr    <= 1'b0;
                bit_cnt <= '0;
            end
            if (samp && state == RX_DATA) begin
                shift[bit_cnt] <= bit_v;
                bit_cnt        <= last_data ? 3'd0 : bit_cnt + 3'd1;
            end
            if (samp && state == RX_PARITY) perr <= ^shift ^ bit_v;
            if (samp && state == RX_STOP) begin
                ferr    <= ferr | ~bit_v;
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    always_ff @(posedge clk_i)
        if (rst_i) begin
            bus.rx_data_o       <= '0;
            bus.rx_parity_err_o <= 1'b0;
            bus.rx_frame_err_o  <= 1'b0;
            bus.rx_valid_o      <= 1'b0;
            bus.overrun_o       <= 1'b0;
        end else begin
            bus.overrun_o <= deliver && bus.rx_valid_o && !bus.rx_ready_i;
            if (deliver && !(bus.rx_valid_o && !bus.rx_ready_i)) begin
                bus.rx_data_o       <= shift;
                bus.rx_parity_err_o <= perr;
                bus.rx_frame_err_o  <= ferr | ~bit_v;
                bus.rx_valid_o      <= 1'b1;
            end else if (!deliver && bus.rx_ready_i) bus.rx_valid_o <= 1'b0;
        end
    assign bus.busy_o = state != RX_IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into uart_rx, expected words queued and checked by a monitor on accept.
module tb_uart_rx;
    localparam int ClkHz = 10_000_000;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    uart_rx_if bus();
    uart_rx #(.ClkFreqHz(ClkHz)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
    typedef struct packed {logic [7:0] d; logic p; logic f;} exp_t;
    exp_t expq[$];
    int checks = 0, errors = 0, ovr_cnt = 0;
    int bc_fast, bc_slow;
    task automatic check(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask
    always @(negedge clk) if (!rst) begin
        if (bus.overrun_o) ovr_cnt++;
        if (bus.rx_valid_o && bus.rx_ready_i) begin
            if (expq.size() == 0) check("unexpected_word", 1, 0);
            else begin
                exp_t e;
                e = expq.pop_front();
                check("rx_data", bus.rx_data_o, e.d);
                check("parity_err", bus.rx_parity_err_o, e.p);
                check("frame_err", bus.rx_frame_err_o, e.f);
            end
        end
    end
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic drive_bit(input logic b, input int bc);
        bus.rx_i = b;
        idle(bc);
    endtask
    task automatic send_frame(input logic [7:0] d, input int nbits, input bit pen, input bit pval,
                              input int nstop, input bit sval, input int bc);
        drive_bit(1'b0, bc);
        for (int i = 0; i < nbits; i++) drive_bit(d[i], bc);
        if (pen) drive_bit(pval, bc);
        for (int i = 0; i < nstop; i++) drive_bit(sval, bc);
        bus.rx_i = 1'b1;
    endtask
    task automatic wait_valid(input string nm, input int budget);
        int n = 0;
        while (!bus.rx_valid_o && n < budget) begin
            idle(1);
            n++;
        end
        check(nm, bus.rx_valid_o, 1);
    endtask
    task automatic accept();
        bus.rx_ready_i = 1'b1;
        idle(1);
        bus.rx_ready_i = 1'b0;
    endtask
    initial begin
        #5ms;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
    initial begin
        bc_fast = (ClkHz / (115200 * 16)) * 16;
        bc_slow = (ClkHz / (9600 * 16)) * 16;
        bus.rx_i = 1'b1; bus.rx_ready_i = 1'b0; bus.cfg_i = 5'b11000; bus.baud_sel_i = 2'b10;
        idle(5);
        check("rst_valid", bus.rx_valid_o, 0);
        check("rst_data", bus.rx_data_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_overrun", bus.overrun_o, 0);
        rst = 1'b0;
        idle(5);
        // 8N1 0xA5, word must hold until accepted
        expq.push_back('{8'hA5, 1'b0, 1'b0});
        send_frame(8'hA5, 8, 0, 0, 1, 1, bc_fast);
        wait_valid("valid_a5", 200);
        idle(40);
        check("hold_valid", bus.rx_valid_o, 1);
        check("hold_data", bus.rx_data_o, 8'hA5);
        accept();
        check("valid_drop", bus.rx_valid_o, 0);
        // 5E2 at 9600, correct parity then wrong parity
        bus.cfg_i = 5'b00011; bus.baud_sel_i = 2'b00;
        expq.push_back('{8'h15, 1'b0, 1'b0});
        send_frame(8'h15, 5, 1, 1, 2, 1, bc_slow);
        wait_valid("valid_5e2", 2000);
        accept();
        bus.baud_sel_i = 2'b10;
        expq.push_back('{8'h15, 1'b1, 1'b0});
        send_frame(8'h15, 5, 1, 0, 2, 1, bc_fast);
        wait_valid("valid_5e2_perr", 200);
        accept();
        // framing error
        bus.cfg_i = 5'b11000;
        expq.push_back('{8'h3C, 1'b0, 1'b1});
        send_frame(8'h3C, 8, 0, 0, 1, 0, bc_fast);
        idle(bc_fast);
        wait_valid("valid_ferr", 200);
        accept();
        // back-to-back with ready low: second frame dropped
        expq.push_back('{8'h11, 1'b0, 1'b0});
        send_frame(8'h11, 8, 0, 0, 1, 1, bc_fast);
        send_frame(8'h22, 8, 0, 0, 1, 1, bc_fast);
        idle(bc_fast);
        wait_valid("valid_ovr", 200);
        check("ovr_keep", bus.rx_data_o, 8'h11);
        check("ovr_pulses", ovr_cnt, 1);
        accept();
        check("ovr_valid_drop", bus.rx_valid_o, 0);
        // false start of 4 ticks
        bus.rx_i = 1'b0;
        idle(4 * bc_fast / 16);
        bus.rx_i = 1'b1;
        idle(3 * bc_fast);
        check("false_busy", bus.busy_o, 0);
        check("false_valid", bus.rx_valid_o, 0);
        expq.push_back('{8'h7E, 1'b0, 1'b0});
        send_frame(8'h7E, 8, 0, 0, 1, 1, bc_fast);
        wait_valid("valid_7e", 200);
        accept();
        // break: zeros with frame error, no second frame while low
        expq.push_back('{8'h00, 1'b0, 1'b1});
        bus.rx_i = 1'b0;
        idle(25 * bc_fast);
        bus.rx_i = 1'b1;
        idle(bc_fast);
        wait_valid("valid_break", 200);
        accept();
        idle(2 * bc_fast);
        check("break_single", bus.rx_valid_o, 0);
        // reset mid-frame discards buffered word
        send_frame(8'h55, 8, 0, 0, 1, 1, bc_fast);
        wait_valid("valid_55", 200);
        bus.rx_i = 1'b0;
        idle(3 * bc_fast);
        check("busy_mid", bus.busy_o, 1);
        rst = 1'b1;
        idle(2);
        bus.rx_i = 1'b1;
        rst = 1'b0;
        idle(3 * bc_fast);
        check("rst_mid_valid", bus.rx_valid_o, 0);
        check("rst_mid_busy", bus.busy_o, 0);
        check("queue_empty", expq.size(), 0);
        check("ovr_total", ovr_cnt, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
